// File: rtl/wr_req_scheduler.sv
// rtl/wr_req_scheduler.sv - round-robin, credit-gated write-request scheduler onto the shared sq_wr queue
// Ports:
//   clk, rst           sole clock; synchronous active-high reset
//   req_valid/ready    per-stream request handshake (req_ready is the combinational grant strobe)
//   req_vaddr/len/last per-stream request payload, stream i in slice i
//   sq_*               registered shared write-request slot with sq_ready backpressure
//   cq_valid, cq_dest  write completion, always accepted
//   cmpl_pulse         registered one-cycle completion strobe per stream
//   outstanding        per-stream issued-but-uncompleted count, CNT_W bits per stream
//   err_underflow      sticky: completion for a stream with nothing outstanding
//   err_bad_dest       sticky: completion addressed to a non-existent stream
module wr_req_scheduler #(
    parameter int N_STREAMS       = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int VADDR_W         = 48,
    parameter int LEN_W           = 28,
    parameter int ID_W            = 4,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1),
    localparam int PTR_W          = (N_STREAMS > 1) ? $clog2(N_STREAMS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_STREAMS-1:0]         req_valid,
    output logic [N_STREAMS-1:0]         req_ready,
    input  logic [N_STREAMS*VADDR_W-1:0] req_vaddr,
    input  logic [N_STREAMS*LEN_W-1:0]   req_len,
    input  logic [N_STREAMS-1:0]         req_last,
    output logic                         sq_valid,
    input  logic                         sq_ready,
    output logic [VADDR_W-1:0]           sq_vaddr,
    output logic [LEN_W-1:0]             sq_len,
    output logic [ID_W-1:0]              sq_dest,
    output logic                         sq_last,
    input  logic                         cq_valid,
    input  logic [ID_W-1:0]              cq_dest,
    output logic [N_STREAMS-1:0]         cmpl_pulse,
    output logic [N_STREAMS*CNT_W-1:0]   outstanding,
    output logic                         err_underflow,
    output logic                         err_bad_dest
);

    typedef enum logic {EMPTY, FULL} slot_state_t;

    slot_state_t          state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]     cnt [N_STREAMS];

    logic [N_STREAMS-1:0] eligible;
    logic [N_STREAMS-1:0] cq_hit;
    logic                 found;
    logic                 grant;
    logic [PTR_W-1:0]     winner;
    logic [PTR_W-1:0]     next_ptr;
    logic [VADDR_W-1:0]   sel_vaddr;
    logic [LEN_W-1:0]     sel_len;
    logic                 sel_last;
    logic                 cq_in_range;

    assign sq_valid    = (state == FULL);
    assign cq_in_range = ({1'b0, cq_dest} < (ID_W + 1)'(N_STREAMS));
    assign grant       = found && (!sq_valid || sq_ready) && !rst;
    assign next_ptr    = (winner == PTR_W'(N_STREAMS - 1)) ? '0 : winner + 1'b1;

    // Two upward passes: streams at or above the pointer win first, then the wrap-around part.
    always_comb begin
        eligible = '0;
        found    = 1'b0;
        winner   = '0;
        for (int i = 0; i < N_STREAMS; i++)
            eligible[i] = req_valid[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
        for (int i = 0; i < N_STREAMS; i++) begin
            if (!found && eligible[i] && (PTR_W'(i) >= rr_ptr)) begin
                found  = 1'b1;
                winner = PTR_W'(i);
            end
        end
        for (int i = 0; i < N_STREAMS; i++) begin
            if (!found && eligible[i]) begin
                found  = 1'b1;
                winner = PTR_W'(i);
            end
        end
    end

    always_comb begin
        req_ready   = '0;
        cq_hit      = '0;
        outstanding = '0;
        sel_vaddr   = '0;
        sel_len     = '0;
        sel_last    = 1'b0;
        for (int i = 0; i < N_STREAMS; i++) begin
            req_ready[i] = grant && (winner == PTR_W'(i));
            cq_hit[i]    = cq_valid && cq_in_range && (cq_dest == ID_W'(i));
            outstanding[i*CNT_W +: CNT_W] = cnt[i];
            if (winner == PTR_W'(i)) begin
                sel_vaddr = req_vaddr[i*VADDR_W +: VADDR_W];
                sel_len   = req_len[i*LEN_W +: LEN_W];
                sel_last  = req_last[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= EMPTY;
            rr_ptr        <= '0;
            sq_vaddr      <= '0;
            sq_len        <= '0;
            sq_dest       <= '0;
            sq_last       <= 1'b0;
            cmpl_pulse    <= '0;
            err_underflow <= 1'b0;
            err_bad_dest  <= 1'b0;
            for (int i = 0; i < N_STREAMS; i++)
                cnt[i] <= '0;
        end else begin
            case (state)
                EMPTY:   if (grant) state <= FULL;
                FULL:    if (sq_ready && !grant) state <= EMPTY;
                default: state <= EMPTY;
            endcase

            if (grant) begin
                sq_vaddr <= sel_vaddr;
                sq_len   <= sel_len;
                sq_last  <= sel_last;
                sq_dest  <= ID_W'(winner);
                rr_ptr   <= next_ptr;
            end

            if (cq_valid && !cq_in_range)
                err_bad_dest <= 1'b1;

            // Credits are taken at grant time so a stalled slot still counts against its stream.
            // A completion on an empty counter is flagged but cannot take the count below zero.
            for (int i = 0; i < N_STREAMS; i++) begin
                cmpl_pulse[i] <= cq_hit[i];
                if (cq_hit[i] && (cnt[i] == '0))
                    err_underflow <= 1'b1;
                if (req_ready[i] && !(cq_hit[i] && (cnt[i] != '0)))
                    cnt[i] <= cnt[i] + 1'b1;
                else if (!req_ready[i] && cq_hit[i] && (cnt[i] != '0))
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wr_req_scheduler.sv
// tb/tb_wr_req_scheduler.sv - self-checking bench for wr_req_scheduler
module tb_wr_req_scheduler;

    localparam int NS   = 4;
    localparam int MAXO = 8;
    localparam int VW   = 48;
    localparam int LW   = 28;
    localparam int IW   = 4;
    localparam int CW   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NS-1:0]    req_valid;
    logic [NS-1:0]    req_ready;
    logic [NS*VW-1:0] req_vaddr;
    logic [NS*LW-1:0] req_len;
    logic [NS-1:0]    req_last;
    logic             sq_valid;
    logic             sq_ready;
    logic [VW-1:0]    sq_vaddr;
    logic [LW-1:0]    sq_len;
    logic [IW-1:0]    sq_dest;
    logic             sq_last;
    logic             cq_valid;
    logic [IW-1:0]    cq_dest;
    logic [NS-1:0]    cmpl_pulse;
    logic [NS*CW-1:0] outstanding;
    logic             err_underflow;
    logic             err_bad_dest;

    always #5 clk = ~clk;

    wr_req_scheduler #(
        .N_STREAMS(NS), .MAX_OUTSTANDING(MAXO), .VADDR_W(VW), .LEN_W(LW), .ID_W(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .req_len(req_len), .req_last(req_last),
        .sq_valid(sq_valid), .sq_ready(sq_ready), .sq_vaddr(sq_vaddr),
        .sq_len(sq_len), .sq_dest(sq_dest), .sq_last(sq_last),
        .cq_valid(cq_valid), .cq_dest(cq_dest), .cmpl_pulse(cmpl_pulse),
        .outstanding(outstanding), .err_underflow(err_underflow), .err_bad_dest(err_bad_dest)
    );

    typedef struct packed {
        logic [IW-1:0] dest;
        logic [VW-1:0] vaddr;
        logic [LW-1:0] len;
        logic          last;
    } sq_t;

    typedef struct {
        logic [NS-1:0] rv;
        logic [NS-1:0] exp_rr;
        int            exp_dest;
    } vec_t;

    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    logic [NS-1:0] last_rr;

    sq_t           sb[$];
    int            m_cnt[NS];
    int            m_ptr;
    bit            m_full;
    bit [NS-1:0]   m_pulse;
    bit            m_uf;
    bit            m_bd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [VW-1:0] exp_vaddr(input int s, input int c);
        return {4'hA, 4'(s), 8'h00, 32'(c)};
    endfunction

    task automatic drive_payload();
        for (int i = 0; i < NS; i++) begin
            req_vaddr[i*VW +: VW] = exp_vaddr(i, cyc);
            req_len[i*LW +: LW]   = LW'(cyc * 4 + i);
            req_last[i]           = ((cyc + i) % 3) == 0;
        end
    endtask

    // One clock: settle inputs, check the grant against the reference arbiter, advance the
    // reference model, then check registered outputs just after the edge.
    task automatic tick();
        int  win;
        bit  can;
        sq_t e;
        drive_payload();
        #3;
        last_rr = req_ready;
        win = -1;
        can = !m_full || sq_ready;
        if (!rst && can) begin
            for (int k = 0; k < NS; k++) begin
                int s;
                s = (m_ptr + k) % NS;
                if (win < 0 && req_valid[s] && m_cnt[s] < MAXO) win = s;
            end
        end
        chk("req_ready", 64'(req_ready), (win >= 0) ? (64'(1) << win) : 64'(0));
        if (rst) begin
            for (int s = 0; s < NS; s++) m_cnt[s] = 0;
            m_ptr = 0; m_full = 0; m_pulse = '0; m_uf = 0; m_bd = 0;
            sb.delete();
        end else begin
            if (m_full && sq_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("hs_dest", 64'(sq_dest), 64'(e.dest));
                chk("hs_vaddr", 64'(sq_vaddr), 64'(e.vaddr));
                chk("hs_len", 64'(sq_len), 64'(e.len));
                chk("hs_last", 64'(sq_last), 64'(e.last));
            end
            m_pulse = '0;
            if (cq_valid) begin
                if (cq_dest >= NS) m_bd = 1;
                else begin
                    m_pulse[cq_dest] = 1'b1;
                    if (m_cnt[cq_dest] == 0) m_uf = 1;
                    else m_cnt[cq_dest]--;
                end
            end
            if (win >= 0) begin
                e.dest  = IW'(win);
                e.vaddr = exp_vaddr(win, cyc);
                e.len   = LW'(cyc * 4 + win);
                e.last  = ((cyc + win) % 3) == 0;
                sb.push_back(e);
                m_cnt[win]++;
                m_ptr = (win + 1) % NS;
            end
            m_full = (win >= 0) || (m_full && !sq_ready);
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("sq_valid", 64'(sq_valid), 64'(m_full));
        for (int s = 0; s < NS; s++)
            chk("outstanding", 64'(outstanding[s*CW +: CW]), 64'(m_cnt[s]));
        chk("cmpl_pulse", 64'(cmpl_pulse), 64'(m_pulse));
        chk("err_underflow", 64'(err_underflow), 64'(m_uf));
        chk("err_bad_dest", 64'(err_bad_dest), 64'(m_bd));
        if (m_full && sb.size() > 0) begin
            chk("slot_dest", 64'(sq_dest), 64'(sb[0].dest));
            chk("slot_vaddr", 64'(sq_vaddr), 64'(sb[0].vaddr));
        end
    endtask

    task automatic drain();
        req_valid = '0;
        sq_ready  = 1'b1;
        cq_valid  = 1'b1;
        for (int s = 0; s < NS; s++) begin
            while (m_cnt[s] > 0) begin
                cq_dest = IW'(s);
                tick();
            end
        end
        cq_valid = 1'b0;
        cq_dest  = '0;
    endtask

    vec_t tbl[13];
    int   g;

    initial begin
        tbl[0]  = '{4'hF, 4'h1, 0};
        tbl[1]  = '{4'hF, 4'h2, 1};
        tbl[2]  = '{4'hF, 4'h4, 2};
        tbl[3]  = '{4'hF, 4'h8, 3};
        tbl[4]  = '{4'hF, 4'h1, 0};
        tbl[5]  = '{4'hF, 4'h2, 1};
        tbl[6]  = '{4'hF, 4'h4, 2};
        tbl[7]  = '{4'hF, 4'h8, 3};
        tbl[8]  = '{4'hA, 4'h2, 1};
        tbl[9]  = '{4'hA, 4'h8, 3};
        tbl[10] = '{4'h4, 4'h4, 2};
        tbl[11] = '{4'h1, 4'h1, 0};
        tbl[12] = '{4'h0, 4'h0, 0};

        rst = 1'b1; req_valid = '0; sq_ready = 1'b0; cq_valid = 1'b0; cq_dest = '0;
        req_vaddr = '0; req_len = '0; req_last = '0;
        tick();
        tick();
        chk("rst_sq_valid", 64'(sq_valid), 64'(0));
        chk("rst_req_ready", 64'(last_rr), 64'(0));
        chk("rst_outstanding", 64'(outstanding), 64'(0));
        chk("rst_cmpl_pulse", 64'(cmpl_pulse), 64'(0));
        chk("rst_flags", 64'({err_underflow, err_bad_dest}), 64'(0));
        chk("rst_sq_vaddr", 64'(sq_vaddr), 64'(0));
        rst = 1'b0;

        // Round-robin order and one-cycle latency onto sq_dest.
        sq_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            req_valid = tbl[i].rv;
            tick();
            chk("rr_table", 64'(last_rr), 64'(tbl[i].exp_rr));
            if (tbl[i].exp_rr != '0) chk("dest_latency", 64'(sq_dest), 64'(tbl[i].exp_dest));
        end
        drain();

        // Credit limit on stream 2, then a single completion frees one credit.
        req_valid = 4'b0100;
        for (int i = 0; i < 10; i++) tick();
        chk("credit_block_rr", 64'(last_rr), 64'(0));
        chk("credit_full_cnt", 64'(outstanding[2*CW +: CW]), 64'(8));
        req_valid = 4'b0101;
        tick();
        chk("credit_other", 64'(last_rr), 64'(4'b0001));
        cq_valid = 1'b1; cq_dest = 4'd2;
        tick();
        chk("credit_still_blocked", 64'(last_rr), 64'(4'b0001));
        chk("credit_cnt_7", 64'(outstanding[2*CW +: CW]), 64'(7));
        chk("credit_pulse", 64'(cmpl_pulse), 64'(4'b0100));
        cq_valid = 1'b0;
        tick();
        chk("credit_regrant", 64'(last_rr), 64'(4'b0100));
        drain();

        // Backpressure: slot holds for 5 stalled cycles, then handshake and reload together.
        req_valid = 4'hF; sq_ready = 1'b0;
        g = cyc;
        tick();
        chk("bp_first", 64'(last_rr), 64'(4'b1000));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_rr_low", 64'(last_rr), 64'(0));
            chk("bp_valid", 64'(sq_valid), 64'(1));
            chk("bp_vaddr", 64'(sq_vaddr), 64'(exp_vaddr(3, g)));
            chk("bp_dest", 64'(sq_dest), 64'(3));
        end
        sq_ready = 1'b1;
        tick();
        chk("bp_reload_rr", 64'(last_rr), 64'(4'b0001));
        chk("bp_reload_valid", 64'(sq_valid), 64'(1));
        chk("bp_reload_dest", 64'(sq_dest), 64'(0));
        req_valid = '0;
        tick();
        drain();

        // Grant and completion on stream 1 in the same cycle.
        req_valid = 4'b0010;
        for (int i = 0; i < 3; i++) tick();
        cq_valid = 1'b1; cq_dest = 4'd1;
        tick();
        chk("same_cycle_rr", 64'(last_rr), 64'(4'b0010));
        chk("same_cycle_cnt", 64'(outstanding[1*CW +: CW]), 64'(3));
        chk("same_cycle_pulse", 64'(cmpl_pulse), 64'(4'b0010));
        req_valid = '0; cq_valid = 1'b0;
        tick();
        chk("pulse_one_cycle", 64'(cmpl_pulse), 64'(0));
        drain();

        // Error flags.
        cq_valid = 1'b1; cq_dest = 4'd0;
        tick();
        chk("underflow_flag", 64'(err_underflow), 64'(1));
        chk("underflow_cnt", 64'(outstanding[0 +: CW]), 64'(0));
        chk("underflow_pulse", 64'(cmpl_pulse), 64'(4'b0001));
        cq_dest = 4'd7;
        tick();
        chk("bad_dest_flag", 64'(err_bad_dest), 64'(1));
        chk("bad_dest_pulse", 64'(cmpl_pulse), 64'(0));
        cq_valid = 1'b0;
        tick();
        chk("flags_sticky", 64'({err_underflow, err_bad_dest}), 64'(2'b11));

        // Reset while a request is pending and counts are nonzero.
        req_valid = 4'hF; sq_ready = 1'b0;
        tick();
        tick();
        chk("pre_rst_valid", 64'(sq_valid), 64'(1));
        rst = 1'b1;
        tick();
        chk("mid_rst_rr", 64'(last_rr), 64'(0));
        chk("mid_rst_valid", 64'(sq_valid), 64'(0));
        chk("mid_rst_cnt", 64'(outstanding), 64'(0));
        chk("mid_rst_flags", 64'({err_underflow, err_bad_dest}), 64'(0));
        rst = 1'b0; sq_ready = 1'b1;
        tick();
        chk("mid_rst_ptr0", 64'(last_rr), 64'(4'b0001));
        req_valid = '0; cq_valid = 1'b1; cq_dest = 4'd3;
        tick();
        chk("late_cmpl_underflow", 64'(err_underflow), 64'(1));
        cq_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
